buffer_stream_reader: RTL

//  Read-side sequencer for the input_buffer RAM: on start, fetches LEN words from BASE_ADDR upward.

---
 rtl/buffer_stream_reader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/buffer_stream_reader.sv
// Read-side sequencer for the input buffer RAM: fetches len words from
// base_addr upward, absorbs the buffer's 1-cycle read latency, and presents
// the words as a valid/ready stream backed by a small skid FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; no reads, no stream words
// S_RUN   | issuing buffer reads, streaming returned words
// S_DRAIN | all reads issued; waiting for the last word to be accepted
module buffer_stream_reader #(
    parameter int RD_DATA_WIDTH = 16,
    parameter int RD_ADDR_WIDTH = 8,
    parameter int SKID_DEPTH    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [RD_ADDR_WIDTH-1:0]        base_addr,
    input  logic [RD_ADDR_WIDTH-1:0]        len,
    output logic                            busy,
    output logic                            done,
    output logic                            rd_en,
    output logic [RD_ADDR_WIDTH-1:0]        rd_addr,
    input  logic signed [RD_DATA_WIDTH-1:0] rd_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic signed [RD_DATA_WIDTH-1:0] m_data,
    output logic                            m_last
);

    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int OW = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                           state, state_nx;
    logic [RD_ADDR_WIDTH-1:0]         issue_cnt;
    logic [RD_ADDR_WIDTH-1:0]         out_cnt;
    logic                             inflight;
    logic signed [RD_DATA_WIDTH-1:0]  fifo_mem [SKID_DEPTH];
    logic [PW-1:0]                    wr_ptr, rd_ptr;
    logic [OW-1:0]                    occ;
    logic                             push, pop;
    logic [OW:0]                      pend, room;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Stream outputs are decoded from FIFO registers only, so m_ready never reaches m_valid.
    assign m_valid = (occ != '0);
    assign m_data  = fifo_mem[rd_ptr];
    assign m_last  = m_valid && (out_cnt == RD_ADDR_WIDTH'(1));
    assign busy    = (state != S_IDLE);
    assign push    = inflight;
    assign pop     = m_valid && m_ready;

    // A read may issue only if its word is guaranteed a FIFO slot when it returns.
    assign pend = {1'b0, occ} + {{OW{1'b0}}, inflight};
    assign room = (OW+1)'(SKID_DEPTH) + {{OW{1'b0}}, pop};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state and read-issue decode.
    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (len != '0)) state_nx = S_RUN;
                end
                S_RUN: begin
                    if ((issue_cnt != '0) && (pend < room)) rd_en = 1'b1;
                    if (rd_en && (issue_cnt == RD_ADDR_WIDTH'(1))) state_nx = S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && (out_cnt == RD_ADDR_WIDTH'(1))) state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Address/counters, read-return tracking, skid FIFO and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr   <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            done      <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // The word returning next cycle (if any) is dropped with inflight.
                issue_cnt <= '0;
                out_cnt   <= '0;
                inflight  <= 1'b0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                occ       <= '0;
            end else begin
                inflight <= rd_en;
                if ((state == S_IDLE) && start) begin
                    if (len == '0) begin
                        done <= 1'b1;
                    end else begin
                        rd_addr   <= base_addr;
                        issue_cnt <= len;
                        out_cnt   <= len;
                    end
                end
                if (rd_en) begin
                    rd_addr   <= rd_addr + RD_ADDR_WIDTH'(1);
                    issue_cnt <= issue_cnt - RD_ADDR_WIDTH'(1);
                end
                if (push) begin
                    fifo_mem[wr_ptr] <= rd_data;
                    wr_ptr           <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr  <= ptr_inc(rd_ptr);
                    out_cnt <= out_cnt - RD_ADDR_WIDTH'(1);
                    if (out_cnt == RD_ADDR_WIDTH'(1)) done <= 1'b1;
                end
                case ({push, pop})
                    2'b10:   occ <= occ + OW'(1);
                    2'b01:   occ <= occ - OW'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

endmodule
